// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the Tx (and later Rx) paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } tx_state_e;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned UART_DATA_W          = 8;

    // Counter/index width, never below one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last cycle.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int unsigned      CNT_W = clog2_min1(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        bit_end = enable && (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_end ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, DATA_W bits LSB-first, optional parity, 1/2 stop bits.
// Parity bit is included only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_W       = UART_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_en,
    input  logic              two_stop,
    input  logic              odd_parity,
    input  logic              control_status,
    input  logic [DATA_W-1:0] tx_data,
    output logic              start_ack,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      IDX_W    = clog2_min1(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state, state_n;
    logic [DATA_W-1:0] shift_reg, shift_n;
    logic [DATA_W-1:0] data_lat;
    logic [IDX_W-1:0]  bit_idx, idx_n;
    logic              two_stop_lat, odd_lat;
    logic              launch, bit_end, par_bit;
    logic              tx_out_n, busy_n, done_n;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (state != IDLE),
        .bit_end(bit_end)
    );

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        idx_n   = bit_idx;
        launch  = 1'b0;
        par_bit = (^data_lat) ^ odd_lat;

        case (state)
            IDLE: begin
                if (control_status && tx_en) begin
                    launch  = 1'b1;
                    state_n = START;
                    shift_n = tx_data;
                    idx_n   = '0;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift_reg >> 1;
                    if (bit_idx == LAST_IDX) begin
                        idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP1;
`endif
                    end else begin
                        idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP1;
            end
            STOP1: begin
                if (bit_end) state_n = two_stop_lat ? STOP2 : IDLE;
            end
            STOP2: begin
                if (bit_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Line level is derived from the next state so tx_out stays a pure register.
        case (state_n)
            START:   tx_out_n = 1'b0;
            DATA:    tx_out_n = shift_n[0];
            PARITY:  tx_out_n = par_bit;
            default: tx_out_n = 1'b1;
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state != IDLE) && (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            data_lat     <= '0;
            bit_idx      <= '0;
            two_stop_lat <= 1'b0;
            odd_lat      <= 1'b0;
            tx_out       <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            start_ack    <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_idx   <= idx_n;
            tx_out    <= tx_out_n;
            busy      <= busy_n;
            done      <= done_n;
            start_ack <= launch;
            if (launch) begin
                data_lat     <= tx_data;
                two_stop_lat <= two_stop;
                odd_lat      <= odd_parity;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl (CLKS_PER_BIT = 4); adapts to UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en, two_stop, odd_parity, control_status;
    logic [7:0] tx_data;
    logic       start_ack, tx_out, busy, done;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_en         (tx_en),
        .two_stop      (two_stop),
        .odd_parity    (odd_parity),
        .control_status(control_status),
        .tx_data       (tx_data),
        .start_ack     (start_ack),
        .tx_out        (tx_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         two_stop;
        bit         odd;
        int         exp_len;
        int         abort_cyc;
        bit         b2b;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Frame length in cycles from the hand-counted parity-enabled figure.
    function automatic int flen(input int with_par);
        return PAR_EN ? with_par : with_par - CPB;
    endfunction

    // Monitor: on each start_ack, pop the expected frame and check it cycle by cycle.
    initial begin
        frame_t     f;
        bit [15:0]  bits;
        int         nb, limit, b, last_done, fidx;
        bit         bad, chk_done_clear;
        logic [2:0] got, want, bad_val;
        last_done      = -100;
        fidx           = 0;
        chk_done_clear = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_done_clear) begin
                check("done_pulse", 32'(done), 32'd0);
                chk_done_clear = 1'b0;
            end
            if (reset || !start_ack) continue;
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(start_ack), 32'd0);
                continue;
            end
            f = exp_q.pop_front();
            fidx++;
            if (f.b2b) check($sformatf("f%0d_b2b_gap", fidx), 32'(cyc - last_done), 32'd1);
            nb = 0;
            bits = '0;
            bits[nb] = 1'b0; nb++;
            for (int i = 0; i < 8; i++) begin bits[nb] = f.data[i]; nb++; end
            if (PAR_EN) begin bits[nb] = (^f.data) ^ f.odd; nb++; end
            bits[nb] = 1'b1; nb++;
            if (f.two_stop) begin bits[nb] = 1'b1; nb++; end
            limit = (f.abort_cyc != 0) ? f.abort_cyc : f.exp_len;
            bad = 1'b0;
            bad_val = '0;
            for (int k = 0; k < limit; k++) begin
                if (k > 0) @(negedge clk);
                if (k == 1) check($sformatf("f%0d_ack_pulse", fidx), 32'(start_ack), 32'd0);
                b    = k / CPB;
                got  = {tx_out, busy, done};
                want = {bits[b], 1'b1, 1'b0};
                if (got !== want && !bad) begin bad = 1'b1; bad_val = got; end
                if ((k % CPB) == CPB - 1 || k == limit - 1) begin
                    check($sformatf("f%0d_bit%0d{tx,busy,done}", fidx, b),
                          32'(bad ? bad_val : want), 32'(want));
                    bad = 1'b0;
                end
            end
            @(negedge clk);
            if (f.abort_cyc != 0) begin
                check($sformatf("f%0d_reset_idle{tx,busy,done}", fidx),
                      32'({tx_out, busy, done}), 32'b100);
                bad = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (done) bad = 1'b1;
                end
                check($sformatf("f%0d_no_done_after_reset", fidx), 32'(bad), 32'd0);
            end else begin
                check($sformatf("f%0d_end{tx,busy,done}", fidx),
                      32'({tx_out, busy, done}), 32'b101);
                last_done      = cyc;
                chk_done_clear = 1'b1;
            end
        end
    end

    task automatic launch(input logic [7:0] d, input bit ts, input bit odd,
                          input int len, input int abort_cyc, input bit b2b);
        frame_t f;
        f.data = d; f.two_stop = ts; f.odd = odd;
        f.exp_len = len; f.abort_cyc = abort_cyc; f.b2b = b2b;
        exp_q.push_back(f);
        tx_en = 1'b1; two_stop = ts; odd_parity = odd; tx_data = d;
        control_status = 1'b1;
        @(posedge clk); #1;
        control_status = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) check({name, "_timeout"}, 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        frame_t f;
        int     n;
        reset = 1'b1; tx_en = 1'b0; two_stop = 1'b0; odd_parity = 1'b0;
        control_status = 1'b0; tx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset{tx,busy,done,ack}", 32'({tx_out, busy, done, start_ack}), 32'b1000);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Even parity, one stop: 0xA5 -> 44 cycles.
        launch(8'hA5, 1'b0, 1'b0, flen(44), 0, 1'b0);
        wait_idle("t1");

        // Odd parity, two stops: 0x00 -> 48 cycles.
        launch(8'h00, 1'b1, 1'b1, flen(48), 0, 1'b0);
        wait_idle("t2");

        // Request pending while disabled, then enable.
        f.data = 8'h5A; f.two_stop = 1'b0; f.odd = 1'b0;
        f.exp_len = flen(44); f.abort_cyc = 0; f.b2b = 1'b0;
        exp_q.push_back(f);
        tx_en = 1'b0; two_stop = 1'b0; odd_parity = 1'b0; tx_data = 8'h5A;
        control_status = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (start_ack || !tx_out || busy) n++;
        end
        check("pend_hold_bad_cycles", 32'(n), 32'd0);
        tx_en = 1'b1;
        @(posedge clk); #1;
        check("pend_launch_ack", 32'(start_ack), 32'd1);
        control_status = 1'b0;
        wait_idle("t3");

        // Mid-frame config changes are ignored.
        launch(8'h3C, 1'b0, 1'b0, flen(44), 0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        tx_data = 8'hFF; two_stop = 1'b1; odd_parity = 1'b1; tx_en = 1'b0;
        wait_idle("t4");
        tx_en = 1'b1;

        // Held request: two frames with one idle cycle between them.
        f.data = 8'h81; f.two_stop = 1'b1; f.odd = 1'b1;
        f.exp_len = flen(48); f.abort_cyc = 0; f.b2b = 1'b0;
        exp_q.push_back(f);
        f.data = 8'h7E; f.b2b = 1'b1;
        exp_q.push_back(f);
        two_stop = 1'b1; odd_parity = 1'b1; tx_data = 8'h81;
        control_status = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'h7E;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!start_ack && n < 200);
        if (n >= 200) check("t5_second_ack_timeout", 32'(start_ack), 32'd1);
        control_status = 1'b0;
        wait_idle("t5");

        // Reset at cycle 15 of a frame, then a normal frame.
        launch(8'hC3, 1'b0, 1'b0, flen(44), 15, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid{tx,busy,done}", 32'({tx_out, busy, done}), 32'b100);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        launch(8'h96, 1'b0, 1'b1, flen(44), 0, 1'b0);
        wait_idle("t6");

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Sequencer for the UART transmit path.
- Consumes the latched configuration and start flag from the Tx control/status register, plus the Tx data byte.
- Generates the bit-period timing and drives the serial line: start bit, 8 data bits LSB-first, optional parity bit, then 1 or 2 stop bits.
- Returns an acknowledge that clears the CSR start flag, and reports busy/done to the bus side.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200). Legal values are ≥ 2.
- DATA_W, 8: data bits per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_en  in  1  transmitter enable, from CSR bit 0
- two_stop  in  1  1 = two stop bits, 0 = one stop bit (CSR bit 1)
- odd_parity  in  1  1 = odd parity, 0 = even parity (CSR bit 2)
- control_status  in  1  start request, from CSR bit 4 (level)
- tx_data  in  DATA_W  byte to send, sampled at launch
- start_ack  out  1  one-cycle pulse at launch; CSR uses it to clear control_status
- tx_out  out  1  serial line; idle high
- busy  out  1  high from launch until the end of the last stop bit
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset: state = IDLE, baud counter = 0, bit index = 0, shift register = 0. Outputs: tx_out = 1, busy = 0, done = 0, start_ack = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE → START when control_status & tx_en at a clock edge. On that edge:
  - latch tx_data, two_stop and odd_parity into internal registers;
  - start_ack = 1 for exactly one cycle;
  - busy = 1.
- If control_status = 1 but tx_en = 0: stay in IDLE, no ack; the request stays pending in the CSR.
- Launch latency: tx_out goes low on the cycle after the launch edge.
- Baud counter:
  - counts 0 .. CLKS_PER_BIT-1 in every non-IDLE state;
  - a bit period ends when counter = CLKS_PER_BIT-1; the counter then wraps to 0 and the FSM advances;
  - each bit lasts exactly CLKS_PER_BIT cycles.
- START: tx_out = 0, then → DATA.
- DATA:
  - tx_out = shift_reg[0]; the register shifts right at each bit end;
  - bit index counts 0 .. DATA_W-1;
  - after index DATA_W-1: → PARITY (feature enabled), otherwise → STOP1.
- PARITY: tx_out = (^data_latched) XOR odd_latched, then → STOP1.
- STOP1: tx_out = 1. At bit end → STOP2 if two_stop_latched, else → IDLE.
- STOP2: tx_out = 1, then → IDLE.
- Frame completion (entry to IDLE):
  - done = 1 for one cycle and busy = 0, both registered and aligned with the entry cycle.
  - A pending request is launched from that IDLE cycle, so the back-to-back gap is exactly one idle-high cycle.
- Configuration changes mid-frame (tx_en, two_stop, odd_parity, tx_data) have no effect on the current frame. All are used from their latched copies. tx_en deasserting mid-frame does not abort the frame.
- Reset mid-frame: on the next edge tx_out = 1 and state = IDLE. No done pulse; a partial frame is allowed on the line.
- All outputs are registered; no combinational path from inputs to tx_out.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state exists and odd_parity is honoured. Frame length = (1 + DATA_W + 1 + stop) × CLKS_PER_BIT.
- Undefined: no PARITY state and odd_parity is ignored. Frame length = (1 + DATA_W + stop) × CLKS_PER_BIT.

Decomposition:
- Package uart_pkg holds:
  - enum tx_state_e {IDLE, START, DATA, PARITY, STOP1, STOP2};
  - localparam DEFAULT_CLKS_PER_BIT = 868;
  - localparam UART_DATA_W = 8.
- Sub-module uart_baud_cnt: counter with clear/enable inputs and a bit_end output, reused later by the Rx path.
- The FSM and shift register stay in uart_tx_ctrl.

Test Plan (all with CLKS_PER_BIT = 4, UART_TX_PARITY_EN defined):
- tx_en = 1, odd_parity = 0, two_stop = 0, tx_data = 0xA5, control_status pulsed → start_ack high exactly one cycle. tx_out reads 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles. done pulses at cycle 44 after launch; busy high for 44 cycles.
- Same with odd_parity = 1, two_stop = 1, tx_data = 0x00 → parity bit = 1, two stop bits, done at cycle 48.
- control_status = 1 with tx_en = 0 → no start_ack, tx_out stays 1. Raise tx_en → launch on the next edge.
- Launch 0x3C, then change tx_data to 0xFF and two_stop to 1 at cycle 10 → line still carries 0x3C with one stop bit.
- Hold control_status high across two frames → second start bit begins exactly one idle cycle after the first frame's done.
- Assert reset at cycle 15 of a frame → next edge gives tx_out = 1, busy = 0, no done. A new request launches normally after reset is released.
